// File: rtl/uart_wb_host_pkg.sv
// rtl/uart_wb_host_pkg.sv - shared UART register map and host FSM encoding
//
// Holds the UART slave register map (base plus byte offsets), the default
// status/tx-data addresses derived from it, the position of the tx-busy
// flag in the status word, and the state encoding used by uart_wb_host.
package uart_wb_host_pkg;

    // UART slave register map
    localparam logic [31:0] UART_BASE         = 32'h3000_0000;
    localparam logic [31:0] UART_REG_RX_OFS   = 32'h0000_0000;
    localparam logic [31:0] UART_REG_STAT_OFS = 32'h0000_0004;
    localparam logic [31:0] UART_REG_TX_OFS   = 32'h0000_0008;

    localparam logic [31:0] UART_STAT_ADR     = UART_BASE + UART_REG_STAT_OFS;
    localparam logic [31:0] UART_TX_ADR       = UART_BASE + UART_REG_TX_OFS;

    // Status word: transmitter still shifting out the previous byte
    localparam int          UART_STAT_TX_BUSY = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_STAT = 2'd1,
        ST_GAP     = 2'd2,
        ST_WR_TX   = 2'd3
    } state_e;

endpackage

// File: rtl/uart_wb_host.sv
// rtl/uart_wb_host.sv - byte stream to Wishbone UART transmitter host
//
// Accepts one byte at a time on s_data/s_valid/s_ready, polls the UART
// status register over Wishbone until the tx-busy flag is clear, then
// writes the byte to the tx-data register. Each bus cycle is bounded by
// an 8-bit ack wait counter; a timeout drops the cycle, discards the byte
// and sets the sticky err flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   s_data/s_valid/s_ready byte input handshake
//   wbm_*                 Wishbone classic master (all outputs registered)
//   done                  one-cycle pulse per byte written
//   err / err_clr         sticky timeout flag and its clear
module uart_wb_host
    import uart_wb_host_pkg::*;
#(
    parameter logic [31:0] STAT_ADR    = UART_STAT_ADR,
    parameter logic [31:0] TX_ADR      = UART_TX_ADR,
    parameter int          TX_BUSY_BIT = UART_STAT_TX_BUSY,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        done,
    output logic        err,
    input  logic        err_clr
);

    state_e      state_q, state_d;
    logic        s_ready_q, s_ready_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  wait_q, wait_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        timed_out;
    logic        tx_busy;
    logic        rdata_unused;

    assign timed_out    = (wait_q == 8'(ACK_TIMEOUT));
    assign tx_busy      = wbm_dat_i[TX_BUSY_BIT];
    assign rdata_unused = ^wbm_dat_i;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        wait_d  = wait_q;
        done_d  = 1'b0;
        // timeout below overrides a same-cycle clear
        err_d   = err_clr ? 1'b0 : err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (s_valid && s_ready_q) begin
                    hold_d  = s_data;
                    wait_d  = 8'd0;
                    state_d = ST_RD_STAT;
                end
            end
            ST_RD_STAT: begin
                if (wbm_ack_i) begin
                    wait_d  = 8'd0;
                    state_d = tx_busy ? ST_GAP : ST_WR_TX;
                end else if (timed_out) begin
                    hold_d  = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            ST_GAP: begin
                wait_d  = 8'd0;
                state_d = ST_RD_STAT;
            end
            ST_WR_TX: begin
                if (wbm_ack_i) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    hold_d  = 8'd0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wait_d  = wait_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are a registered decode of the next state, so they
        // change on the same edge as the state and read 0 whenever idle.
        cyc_d = (state_d == ST_RD_STAT) || (state_d == ST_WR_TX);
        we_d  = (state_d == ST_WR_TX);
        sel_d = cyc_d ? 4'hF : 4'h0;
        adr_d = (state_d == ST_RD_STAT) ? STAT_ADR :
                (state_d == ST_WR_TX)   ? TX_ADR   : 32'h0;
        dat_d = (state_d == ST_WR_TX) ? {24'h0, hold_d} : 32'h0;

        // Held low during the done cycle so a waiting byte is taken the
        // cycle after done, keeping done and accept from coinciding.
        s_ready_d = (state_d == ST_IDLE) && !done_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            s_ready_q <= 1'b0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            hold_q    <= 8'h0;
            wait_q    <= 8'h0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_wb_host.sv
// tb/tb_uart_wb_host.sv - directed self-checking bench for uart_wb_host
module tb_uart_wb_host;

    localparam logic [31:0] STAT_A = 32'h3000_0004;
    localparam logic [31:0] TX_A   = 32'h3000_0008;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;
    logic        done, err, err_clr;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;

    uart_wb_host dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .done      (done),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Bus is in the status read phase
    task automatic chk_rd(input string tag);
        chk({tag, "_rd_cyc"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b110);
        chk({tag, "_rd_adr"}, wbm_adr_o, STAT_A);
        chk({tag, "_rd_sel"}, wbm_sel_o, 4'hF);
    endtask

    // Bus is in the tx-data write phase carrying byte b
    task automatic chk_wr(input string tag, input logic [7:0] b);
        chk({tag, "_wr_cyc"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b111);
        chk({tag, "_wr_adr"}, wbm_adr_o, TX_A);
        chk({tag, "_wr_dat"}, wbm_dat_o, {24'h0, b});
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_bus"}, {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 7'h0);
        chk({tag, "_adr"}, wbm_adr_o, 32'h0);
        chk({tag, "_dat"}, wbm_dat_o, 32'h0);
    endtask

    // Offer byte b in the current cycle (s_ready must already be high),
    // then advance into the first status read cycle.
    task automatic accept(input string tag, input logic [7:0] b);
        s_data  = b;
        s_valid = 1'b1;
        chk({tag, "_ready"}, s_ready, 1'b1);
        step();
        s_valid = 1'b0;
        chk({tag, "_ready_lo"}, s_ready, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; s_data = 8'h0; s_valid = 1'b0;
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; err_clr = 1'b0;

        // Reset state
        step(3);
        chk("rst_ready", s_ready, 1'b0);
        chk_idle_bus("rst");
        chk("rst_done_err", {done, err}, 2'b00);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", s_ready, 1'b1);

        // Zero-wait transfer of 8'h5A: done in the 4th cycle counting accept
        done_base = done_cnt;
        accept("t1", 8'h5A);
        chk_rd("t1");
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0;
        step();
        chk_wr("t1", 8'h5A);
        step();
        wbm_ack_i = 1'b0;
        chk("t1_done", done, 1'b1);
        chk_idle_bus("t1_after");
        step();
        chk("t1_done_lo", done, 1'b0);
        chk("t1_ready", s_ready, 1'b1);
        chk("t1_ndone", done_cnt - done_base, 1);

        // Busy for three status reads, each followed by a one-cycle gap
        done_base = done_cnt;
        accept("t2", 8'h3C);
        for (int i = 0; i < 3; i++) begin
            chk_rd("t2_poll");
            wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0020;
            step();
            wbm_ack_i = 1'b1;   // ack during the gap must be ignored
            chk("t2_gap_cyc", {wbm_cyc_o, wbm_stb_o}, 2'b00);
            chk("t2_gap_adr", wbm_adr_o, 32'h0);
            chk("t2_gap_ready", s_ready, 1'b0);
            step();
        end
        chk_rd("t2_last");
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFDF;   // only busy bit clear
        step();
        chk_wr("t2", 8'h3C);
        step();
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        chk("t2_done", done, 1'b1);
        step(2);
        chk("t2_ndone", done_cnt - done_base, 1);

        // Status read never acked: cyc high for wait counts 0..255, then err
        done_base = done_cnt;
        accept("t3", 8'h77);
        chk_rd("t3_first");
        step(255);
        chk_rd("t3_last");
        chk("t3_err_lo", err, 1'b0);
        step();
        chk_idle_bus("t3_to");
        chk("t3_err", err, 1'b1);
        chk("t3_ready", s_ready, 1'b1);
        chk("t3_ndone", done_cnt - done_base, 0);
        step();
        chk("t3_err_sticky", err, 1'b1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t3_err_clr", err, 1'b0);

        // Write acked exactly when the wait counter reaches 255
        done_base = done_cnt;
        accept("t4", 8'hC3);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk_wr("t4_first", 8'hC3);
        step(255);
        chk_wr("t4_last", 8'hC3);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk("t4_done", done, 1'b1);
        chk("t4_err", err, 1'b0);
        chk_idle_bus("t4_after");
        step();
        chk("t4_ndone", done_cnt - done_base, 1);

        // Reset in the middle of an unacked write
        done_base = done_cnt;
        accept("t5", 8'h11);
        wbm_ack_i = 1'b1;
        step();
        wbm_ack_i = 1'b0;
        chk_wr("t5", 8'h11);
        step(3);
        rst_n = 1'b0;
        #1;
        chk_idle_bus("t5_rst");
        chk("t5_rst_ready", s_ready, 1'b0);
        chk("t5_rst_done_err", {done, err}, 2'b00);
        step(2);
        rst_n = 1'b1;
        step();
        chk("t5_ready", s_ready, 1'b1);
        chk("t5_ndone", done_cnt - done_base, 0);
        accept("t5b", 8'hA5);
        chk_rd("t5b");
        wbm_ack_i = 1'b1;
        step();
        chk_wr("t5b", 8'hA5);
        step();
        wbm_ack_i = 1'b0;
        chk("t5b_done", done, 1'b1);
        step();

        // Back-to-back bytes with s_valid held high
        s_data = 8'h01; s_valid = 1'b1;
        chk("t6_ready1", s_ready, 1'b1);
        step();
        chk_rd("t6a");
        wbm_ack_i = 1'b1;
        step();
        chk_wr("t6a", 8'h01);
        step();
        wbm_ack_i = 1'b0;
        chk("t6a_done", done, 1'b1);
        chk("t6_ready_in_done", s_ready, 1'b0);
        s_data = 8'h02;
        step();
        chk("t6_ready2", s_ready, 1'b1);
        step();
        s_valid = 1'b0;
        chk_rd("t6b");
        wbm_ack_i = 1'b1;
        step();
        chk_wr("t6b", 8'h02);
        step();
        wbm_ack_i = 1'b0;
        chk("t6b_done", done, 1'b1);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
